// File: rtl/multi_sel_sched.sv
// multi_sel_sched: round-robin scheduler sharing one constant-scaling datapath
// (x1, x3, x7, x8) among NREQ requesters, with valid/ready on both sides.
module multi_sel_sched #(
    parameter int NREQ = 4,
    parameter int DW   = 8,
    parameter int OW   = DW + 3,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*DW-1:0]  req_data,
    output logic [NREQ-1:0]     req_ready,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OW-1:0]       out_data,
    output logic [IDW-1:0]      out_id,
    output logic [1:0]          out_phase,
    output logic                out_last,
    output logic                busy
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t         state;
    logic [DW-1:0]  op;
    logic [IDW-1:0] id;
    logic [1:0]     phase;
    logic [IDW-1:0] last;
    logic [OW-1:0]  prod;
    logic           last_beat;

    logic [NREQ-1:0] grant;
    logic            gnt_found;
    logic [IDW-1:0]  gnt_id;
    logic [IDW-1:0]  idx;
    logic [DW-1:0]   gnt_data;

    // Constant scaling by K = {1, 3, 7, 8} built from shifts and adds.
    function automatic logic [OW-1:0] scale(input logic [DW-1:0] v, input logic [1:0] ph);
        logic [OW-1:0] e;
        e = OW'(v);
        case (ph)
            2'd0:    scale = e;
            2'd1:    scale = e + (e << 1);
            2'd2:    scale = e + (e << 1) + (e << 2);
            default: scale = e << 3;
        endcase
    endfunction

    // Round-robin search starting just after the most recent grant; only in IDLE and out of reset.
    always_comb begin
        grant     = '0;
        gnt_found = 1'b0;
        gnt_id    = '0;
        idx       = '0;
        if (state == IDLE && rst) begin
            for (int unsigned k = 1; k <= NREQ; k++) begin
                idx = last + IDW'(k);
                if (!gnt_found && req_valid[idx]) begin
                    gnt_found  = 1'b1;
                    gnt_id     = idx;
                    grant[idx] = 1'b1;
                end
            end
        end
        gnt_data = req_data[int'(gnt_id)*DW +: DW];
    end

    assign req_ready = grant;
    assign out_valid = (state == RUN);
    assign busy      = (state != IDLE);
    assign out_data  = prod;
    assign out_id    = id;
    assign out_phase = phase;
    assign out_last  = last_beat;

    // Scheduler FSM: accept one operand, then step the four product beats under backpressure.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            op        <= '0;
            id        <= '0;
            phase     <= '0;
            last      <= IDW'(NREQ - 1);
            prod      <= '0;
            last_beat <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_found) begin
                        op        <= gnt_data;
                        id        <= gnt_id;
                        last      <= gnt_id;
                        phase     <= 2'd0;
                        prod      <= OW'(gnt_data);
                        last_beat <= 1'b0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (out_ready) begin
                        if (phase != 2'd3) begin
                            phase     <= phase + 2'd1;
                            prod      <= scale(op, phase + 2'd1);
                            last_beat <= (phase == 2'd2);
                        end else begin
                            last_beat <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_sel_sched.sv
// Scoreboard bench for multi_sel_sched: stimulus pushes expected beats, a
// negedge monitor pops and compares every accepted output beat.
module tb_multi_sel_sched;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int OW   = DW + 3;
    localparam int IDW  = 2;

    logic                clk;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*DW-1:0]  req_data;
    logic [NREQ-1:0]     req_ready;
    logic                out_valid;
    logic                out_ready;
    logic [OW-1:0]       out_data;
    logic [IDW-1:0]      out_id;
    logic [1:0]          out_phase;
    logic                out_last;
    logic                busy;

    typedef struct {
        int data;
        int id;
        int phase;
        int last;
    } beat_t;

    beat_t sb[$];
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int last_grant_cyc = 0;

    multi_sel_sched #(.NREQ(NREQ), .DW(DW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_id(out_id), .out_phase(out_phase),
        .out_last(out_last), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int i, input int v);
        req_data[i*DW +: DW] = v[DW-1:0];
    endtask

    task automatic push4(input int id, input int b0, input int b1, input int b2, input int b3);
        beat_t b;
        b.id = id;
        b.data = b0; b.phase = 0; b.last = 0; sb.push_back(b);
        b.data = b1; b.phase = 1; b.last = 0; sb.push_back(b);
        b.data = b2; b.phase = 2; b.last = 0; sb.push_back(b);
        b.data = b3; b.phase = 3; b.last = 1; sb.push_back(b);
    endtask

    // Entered just after a posedge; returns before the accepting edge.
    task automatic wait_grant(input int exp_id, input int exp_gap);
        int n = 0;
        logic [NREQ-1:0] one;
        #2;
        while (req_ready == '0 && n < 40) begin
            @(posedge clk);
            #3;
            n++;
        end
        if (req_ready == '0) begin
            chk("grant_timeout", 0, 1);
        end else begin
            one = '0;
            one[exp_id] = 1'b1;
            chk("grant_onehot", int'(req_ready), int'(one));
            if (exp_gap > 0) chk("grant_gap", cyc - last_grant_cyc, exp_gap);
            last_grant_cyc = cyc;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            tick();
            n++;
        end
        chk("drain_left", sb.size(), 0);
    endtask

    // Monitor: every accepted beat must match the head of the scoreboard.
    always @(negedge clk) begin
        beat_t e;
        if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_beat: got data %0d id %0d expected none", out_data, out_id);
            end else begin
                e = sb.pop_front();
                chk("beat_data", int'(out_data), e.data);
                chk("beat_id", int'(out_id), e.id);
                chk("beat_phase", int'(out_phase), e.phase);
                chk("beat_last", int'(out_last), e.last);
            end
        end
    end

    initial begin
        int d[4];
        int c0;
        int nb;
        int n;
        rst = 1'b0;
        req_valid = '1;
        req_data = '0;
        out_ready = 1'b1;

        // Reset state, with requests pending while rst is low
        tick();
        tick();
        chk("rst_req_ready", int'(req_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_last", int'(out_last), 0);
        req_valid = '0;
        rst = 1'b1;
        tick();

        // Fairness: all valid, order 0,1,2,3,0 spaced 5 cycles
        d[0] = 'h11; d[1] = 'h22; d[2] = 'h33; d[3] = 'h44;
        for (int i = 0; i < NREQ; i++) set_data(i, d[i]);
        req_valid = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            wait_grant(g % NREQ, (g == 0) ? 0 : 5);
            push4(g % NREQ, d[g%NREQ]*1, d[g%NREQ]*3, d[g%NREQ]*7, d[g%NREQ]*8);
            tick();
        end
        req_valid = '0;
        drain();

        // Sparse fairness: only req1 and req3
        req_valid = 4'b1010;
        for (int g = 0; g < 4; g++) begin
            wait_grant((g % 2 == 0) ? 1 : 3, (g == 0) ? 0 : 5);
            push4((g % 2 == 0) ? 1 : 3, d[(g%2==0)?1:3]*1, d[(g%2==0)?1:3]*3,
                  d[(g%2==0)?1:3]*7, d[(g%2==0)?1:3]*8);
            tick();
        end
        req_valid = '0;
        drain();

        // Single requester: req0 = 0x05
        set_data(0, 'h05);
        req_valid = 4'b0001;
        wait_grant(0, 0);
        push4(0, 5, 15, 35, 40);
        tick();
        req_valid = '0;
        #2;
        chk("single_ready_drop", int'(req_ready), 0);
        nb = 0;
        for (int i = 0; i < 8; i++) begin
            if (busy) nb++;
            tick();
        end
        chk("single_busy_cycles", nb, 4);
        drain();

        // Width limit: req2 = 0xFF
        set_data(2, 'hFF);
        req_valid = 4'b0100;
        wait_grant(2, 0);
        push4(2, 255, 765, 1785, 2040);
        tick();
        req_valid = '0;
        drain();

        // Backpressure: req1 = 0x05, out_ready low 3 cycles during phase 1
        set_data(1, 'h05);
        req_valid = 4'b0010;
        wait_grant(1, 0);
        c0 = cyc;
        push4(1, 5, 15, 35, 40);
        tick();
        req_valid = '0;
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("bp_hold_data", int'(out_data), 15);
            chk("bp_hold_phase", int'(out_phase), 1);
            if (i == 3) out_ready = 1'b1;
            tick();
        end
        n = 0;
        while (busy && n < 20) begin
            tick();
            n++;
        end
        chk("bp_total_cycles", cyc - c0, 8);
        drain();

        // Reset during phase 2 of a req0 operation
        set_data(0, 'h0A);
        req_valid = 4'b0001;
        wait_grant(0, 0);
        push4(0, 10, 30, 70, 80);
        tick();
        req_valid = '0;
        tick();
        tick();
        #1;
        chk("mid_phase_before_rst", int'(out_phase), 2);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("mid_out_valid", int'(out_valid), 0);
        chk("mid_busy", int'(busy), 0);
        chk("mid_out_data", int'(out_data), 0);
        chk("mid_out_id", int'(out_id), 0);
        chk("mid_out_phase", int'(out_phase), 0);
        chk("mid_out_last", int'(out_last), 0);
        chk("mid_sb_left", sb.size(), 2);
        sb.delete();
        set_data(0, 'h03);
        set_data(1, 'h04);
        req_valid = 4'b0011;
        wait_grant(0, 0);
        push4(0, 3, 9, 21, 24);
        tick();
        wait_grant(1, 5);
        push4(1, 4, 12, 28, 32);
        tick();
        req_valid = '0;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
